// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the LFSR checker: FSM state encoding and counter widths.
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Wide enough for LOCK_COUNT / LOSS_COUNT up to 15.
    localparam int RUN_W = 4;

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step advance of a Galois LFSR word.
module lfsr_step #(
    parameter int               NBITS  = 8,
    parameter logic [NBITS-1:0] TAPS   = 8'b11101,
    parameter bit               INVERT = 1'b0
) (
    input  logic [NBITS-1:0] word,
    output logic [NBITS-1:0] next_word
);

    logic feedback;

    assign feedback     = word[NBITS-1] ^ INVERT;
    assign next_word[0] = feedback & TAPS[0];

    generate
        for (genvar gi = 1; gi < NBITS; gi++) begin : g_bit
            assign next_word[gi] = word[gi-1] ^ (feedback & TAPS[gi]);
        end
    endgenerate

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker with lock FSM and saturating error counter.
// Optional repeat-word detector enabled by defining LFSR_CHECK_STUCK_EN.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int               NBITS      = 8,
    parameter logic [NBITS-1:0] TAPS       = 8'b11101,
    parameter bit               INVERT     = 1'b0,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 4,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [NBITS-1:0] in_word,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHECK_STUCK_EN
    ,
    output logic             stuck
`endif
);

    state_t             state_reg, state_next;
    logic [NBITS-1:0]   pred_reg, pred_next;
    logic [RUN_W-1:0]   good_cnt_reg, good_cnt_next;
    logic [RUN_W-1:0]   bad_cnt_reg, bad_cnt_next;
    logic               err_pulse_reg, err_pulse_next;
    logic [CNT_W-1:0]   err_count_reg, err_count_next;
    logic [NBITS-1:0]   seed_step;
    logic [NBITS-1:0]   fly_step;
    logic               match;

    // Reseed path follows the received word; flywheel path follows the predictor only.
    lfsr_step #(.NBITS(NBITS), .TAPS(TAPS), .INVERT(INVERT)) u_seed_step (
        .word      (in_word),
        .next_word (seed_step)
    );

    lfsr_step #(.NBITS(NBITS), .TAPS(TAPS), .INVERT(INVERT)) u_fly_step (
        .word      (pred_reg),
        .next_word (fly_step)
    );

    assign match = (in_word == pred_reg);

    always_comb begin
        state_next     = state_reg;
        pred_next      = pred_reg;
        good_cnt_next  = good_cnt_reg;
        bad_cnt_next   = bad_cnt_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;
        if (in_valid) begin
            case (state_reg)
                SEARCH: begin
                    pred_next     = seed_step;
                    good_cnt_next = '0;
                    state_next    = VERIFY;
                end
                VERIFY: begin
                    pred_next = seed_step;
                    if (match) begin
                        good_cnt_next = good_cnt_reg + 1'b1;
                        if (good_cnt_reg + 1'b1 == RUN_W'(LOCK_COUNT)) begin
                            state_next   = LOCKED;
                            bad_cnt_next = '0;
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    pred_next = fly_step;
                    if (match) begin
                        bad_cnt_next = '0;
                    end else begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != {CNT_W{1'b1}}) begin
                            err_count_next = err_count_reg + 1'b1;
                        end
                        if (bad_cnt_reg + 1'b1 == RUN_W'(LOSS_COUNT)) begin
                            state_next    = SEARCH;
                            bad_cnt_next  = '0;
                            good_cnt_next = '0;
                        end else begin
                            bad_cnt_next = bad_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
        if (clear) begin
            err_count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SEARCH;
            pred_reg      <= '0;
            good_cnt_reg  <= '0;
            bad_cnt_reg   <= '0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pred_reg      <= pred_next;
            good_cnt_reg  <= good_cnt_next;
            bad_cnt_reg   <= bad_cnt_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
        end
    end

    assign locked    = (state_reg == LOCKED);
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;

`ifdef LFSR_CHECK_STUCK_EN
    logic [NBITS-1:0] last_word_reg;
    logic             have_last_reg;
    logic             stuck_reg;

    // have_last_reg keeps the first word after reset from comparing against the cleared register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_word_reg <= '0;
            have_last_reg <= 1'b0;
            stuck_reg     <= 1'b0;
        end else begin
            stuck_reg <= in_valid && have_last_reg && (in_word == last_word_reg);
            if (in_valid) begin
                last_word_reg <= in_word;
                have_last_reg <= 1'b1;
            end
        end
    end

    assign stuck = stuck_reg;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a word-level reference model queues expected outputs,
// a negedge monitor compares them against the DUT each cycle.
module tb_lfsr_checker;

    localparam int         NBITS      = 8;
    localparam logic [7:0] TAPS       = 8'b11101;
    localparam bit         INVERT     = 1'b0;
    localparam int         LOCK_COUNT = 4;
    localparam int         LOSS_COUNT = 4;
    localparam int         CNT_W      = 4;
    localparam int         CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [NBITS-1:0] in_word = '0;
    logic             clear = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
`ifdef LFSR_CHECK_STUCK_EN
    logic             stuck;
`endif

    lfsr_checker #(
        .NBITS(NBITS), .TAPS(TAPS), .INVERT(INVERT),
        .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
`ifdef LFSR_CHECK_STUCK_EN
        ,
        .stuck     (stuck)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int pulse;
        int err;
        int stuck;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference model state: 0 = searching, 1 = verifying, 2 = locked.
    int m_mode, m_pred, m_good, m_bad, m_err, m_pulse, m_stuck, m_last, m_have_last;

    function automatic int step(input int w);
        int n;
        n = (w << 1) & ((1 << NBITS) - 1);
        if ((((w >> (NBITS - 1)) & 1) ^ int'(INVERT)) != 0) n = n ^ int'(TAPS);
        return n;
    endfunction

    task automatic model(input bit rst, input bit v, input int w, input bit clr);
        if (rst) begin
            m_mode = 0; m_pred = 0; m_good = 0; m_bad = 0;
            m_err = 0; m_pulse = 0; m_stuck = 0; m_last = 0; m_have_last = 0;
            return;
        end
        m_pulse = 0;
        m_stuck = 0;
        if (v) begin
`ifdef LFSR_CHECK_STUCK_EN
            m_stuck = (m_have_last != 0 && w == m_last) ? 1 : 0;
`endif
            m_last = w;
            m_have_last = 1;
            if (m_mode == 0) begin
                m_pred = step(w);
                m_good = 0;
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (w == m_pred) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_mode = 2;
                        m_bad = 0;
                    end
                end else begin
                    m_good = 0;
                end
                m_pred = step(w);
            end else begin
                if (w == m_pred) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1;
                    if (m_err < CNT_MAX) m_err++;
                    m_bad++;
                    if (m_bad == LOSS_COUNT) begin
                        m_mode = 0;
                        m_bad = 0;
                        m_good = 0;
                    end
                end
                m_pred = step(m_pred);
            end
        end
        if (clr) m_err = 0;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic drive(input bit rst, input bit v, input int w, input bit clr);
        exp_t e;
        reset    = rst;
        in_valid = v;
        in_word  = NBITS'(w);
        clear    = clr;
        @(posedge clk);
        model(rst, v, w, clr);
        e.locked = (m_mode == 2) ? 1 : 0;
        e.pulse  = m_pulse;
        e.err    = m_err;
        e.stuck  = m_stuck;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: one expected response per driven cycle, compared once outputs have settled.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            chk("sb_locked", int'(locked), e.locked);
            chk("sb_err_pulse", int'(err_pulse), e.pulse);
            chk("sb_err_count", int'(err_count), e.err);
`ifdef LFSR_CHECK_STUCK_EN
            chk("sb_stuck", int'(stuck), e.stuck);
`endif
            $display("txn %0d: locked=%0d err_pulse=%0d err_count=%0d", txn, locked, err_pulse, err_count);
        end
    end

    int g;

    task automatic feed_good(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, g, 0);
            g = step(g);
        end
    endtask

    task automatic feed_wrong(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, g ^ 1, 0);
            g = step(g);
        end
    endtask

    initial begin
        int r;
        @(negedge clk);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_err_pulse", int'(err_pulse), 0);

        // Known sequence 80,1D,3A,74,E8: lock after the fifth word.
        g = 'h80;
        feed_good(4);
        chk("t1_not_yet_locked", int'(locked), 0);
        feed_good(1);
        chk("t1_locked", int'(locked), 1);
        chk("t1_err_count", int'(err_count), 0);

        // Single corrupted word while locked.
        feed_good(1);
        drive(0, 1, 0, 0);
        g = step(g);
        chk("t2_err_pulse", int'(err_pulse), 1);
        feed_good(1);
        chk("t2_pulse_drops", int'(err_pulse), 0);
        chk("t2_err_count", int'(err_count), 1);
        chk("t2_still_locked", int'(locked), 1);
        feed_good(2);

        // Four consecutive errors drop lock; five good words relock.
        feed_wrong(3);
        chk("t3_locked_after_3", int'(locked), 1);
        feed_wrong(1);
        chk("t3_err_count", int'(err_count), 5);
        chk("t3_lost_lock", int'(locked), 0);
        feed_good(5);
        chk("t3_relocked", int'(locked), 1);

        // Bad word in the middle of verification just reseeds.
        drive(1, 0, 0, 0);
        g = 'h5B;
        feed_good(3);
        drive(0, 1, g ^ 1, 0);
        chk("t4_no_pulse", int'(err_pulse), 0);
        g = step(g ^ 1);
        feed_good(3);
        chk("t4_not_locked", int'(locked), 0);
        feed_good(1);
        chk("t4_locked", int'(locked), 1);
        chk("t4_err_count", int'(err_count), 0);

        // Drive the counter into saturation, then clear against a simultaneous error.
        for (int k = 0; k < 4; k++) begin
            feed_wrong(4);
            feed_good(5);
        end
        chk("t5_saturated", int'(err_count), CNT_MAX);
        feed_wrong(1);
        chk("t5_stays_saturated", int'(err_count), CNT_MAX);
        drive(0, 1, g ^ 1, 1);
        g = step(g);
        chk("t5_clear_wins", int'(err_count), 0);
        chk("t5_clear_pulse", int'(err_pulse), 1);

`ifdef LFSR_CHECK_STUCK_EN
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("t6_stuck", int'(stuck), 1);
        drive(0, 0, 0, 0);
        chk("t6_stuck_drops", int'(stuck), 0);
`endif
        g = 'h80;
        feed_good(6);
        drive(1, 1, g, 0);
        chk("t6_reset_locked", int'(locked), 0);
        chk("t6_reset_err_count", int'(err_count), 0);
        chk("t6_reset_err_pulse", int'(err_pulse), 0);

        g = int'($urandom_range(1, 255));
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                feed_good(1);
            end else if (r < 70) begin
                drive(0, 1, g ^ int'($urandom_range(1, 255)), 0);
                g = step(g);
            end else if (r < 80) begin
                drive(0, 0, int'($urandom_range(0, 255)), 0);
            end else if (r < 83) begin
                g = int'($urandom_range(1, 255));
                feed_good(1);
            end else if (r < 87) begin
                drive(0, int'($urandom_range(0, 1)), g, 1);
                if (in_valid) g = step(g);
            end else if (r < 89) begin
                drive(1, 1, g, 0);
            end else begin
                drive(0, 1, int'(in_word), 0);
            end
        end

        in_valid = 1'b0;
        clear    = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
